mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one memory port between N requesters (req 0 = instruction fetch, req 1 = memory-stage load/store).
//  Single-beat accesses; round-robin grant; request latched at grant; response routed back to the owner.
//  Sits between the pipeline fetch/memory stages and the memory/cache interface.
// PARAMETERS
//  N   2   number of requesters (>=2)
//  AW  64  address width
//  DW  64  data width; strobe width DW/8
// PORTS
//  clk          in   1         clock
//  reset        in   1         synchronous, active-high reset
//  up_valid     in   N         requester i holds a request until its up_data_ok pulse
//  up_write     in   N         1 = store, 0 = load
//  up_size      in   N*3       access size code (MSIZE1/2/4/8 encoding)
//  up_addr      in   N*AW      byte address
//  up_strobe    in   N*DW/8    byte enables (store only)
//  up_wdata     in   N*DW      store data, already lane-aligned
//  up_data_ok   out  N         one-cycle completion pulse to requester i
//  up_rdata     out  DW        load data; valid only with an up_data_ok bit
//  dn_valid     out  1         request to memory
//  dn_write     out  1
//  dn_size      out  3
//  dn_addr      out  AW
//  dn_strobe    out  DW/8
//  dn_wdata     out  DW
//  dn_ok        in   1         memory completion (one cycle, only while dn_valid)
//  dn_rdata     in   DW        read data, valid with dn_ok
//  busy         out  1         transaction in flight
// BEHAVIOUR
//  Reset: state ARB_IDLE, all outputs 0, latched request fields 0, last-grant pointer = N-1.
//  The pointer value N-1 gives requester 0 first priority after reset.
//  ARB_IDLE:
//   - If any up_valid is set, pick the first valid index after the pointer, searching cyclically.
//   - Latch that requester's write/size/addr/strobe/wdata and its index into sel.
//   - Go to ARB_BUSY on the next edge.
//  ARB_BUSY:
//   - dn_valid = 1; dn_* are driven only from the latched fields; busy = 1.
//   - On dn_ok: up_data_ok[sel] = 1 and up_rdata = dn_rdata in the same cycle (combinational forward).
//   - On that same edge: pointer <= sel, state <= ARB_IDLE.
//  Latency:
//   - The grant edge is registered, so no path from up_valid to dn_valid in the same cycle.
//   - Minimum up_valid to up_data_ok is 2 cycles (dn_ok arriving in the first BUSY cycle).
//   - After completion there is >=1 ARB_IDLE cycle before the next grant.
//  Fairness: with all requesters continuously valid, grants rotate 0,1,...,N-1,0.
//  Requester drops up_valid mid-transaction (flush):
//   - The latched access still completes and up_data_ok[sel] still pulses.
//   - The requester ignores the pulse.
//   - The arbiter never aborts a dn transaction.
//  Same-cycle events:
//   - Completion and a new up_valid in the same cycle: the new request is not granted that cycle.
//   - It is arbitrated in the following ARB_IDLE cycle using the updated pointer.
//  up_data_ok has exactly one bit set, or none. up_rdata = 0 whenever no bit is set.
//  dn_ok while in ARB_IDLE is ignored.
//  Reset mid-transaction returns to the reset values above. The memory side must discard its outstanding access.
// STRUCTURE
//  Shared package:
//   - arb_state_t enum {ARB_IDLE, ARB_BUSY}.
//   - Size codes (reuse the existing MSIZE constants).
//  Sub-module rr_pick: combinational round-robin picker.
//   - Parameter N.
//   - Inputs req[N] and ptr; outputs gnt_idx and any.
//  Top-level: state register, pointer register, request latch, response demux.
// TESTING
//  1 Reset, then only up_valid[1] (load, addr 0x80000010, size MSIZE8); dn_ok after 3 cycles with rdata 0x1122334455667788
//    -> dn_addr = 0x80000010 with dn_write = 0; up_data_ok = 2'b10; up_rdata = 0x1122334455667788.
//  2 Both requesters valid continuously, dn_ok one cycle after each dn_valid rise
//    -> grant order 0,1,0,1; each grant occupies 3 cycles (idle, busy, busy+ok).
//  3 Req 1 store (addr 0x1004, strobe 0xF0, wdata 0xDEADBEEF00000000); req 0 raises valid while it is busy
//    -> dn_* hold the store fields until dn_ok; req 0 is granted afterwards.
//  4 Req 1 drops up_valid and changes up_addr one cycle after the grant
//    -> dn_addr keeps its latched value; up_data_ok[1] pulses on dn_ok.
//  5 Reset asserted in ARB_BUSY
//    -> next cycle: dn_valid = 0, busy = 0, up_data_ok = 0; the first grant afterwards goes to requester 0.
//  6 dn_ok pulsed in ARB_IDLE with no request
//    -> no up_data_ok, state unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
// Size codes match the rest of the memory subsystem.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches cyclically starting just after the last-granted index.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // first requester after ptr, wrapping at N
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any     = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-beat memory port between N requesters.
// Round-robin grant, request latched at grant, response routed to owner.
module mem_port_arbiter #(
  parameter int N  = 2,
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      up_valid,
  input  logic [N-1:0]      up_write,
  input  logic [N*3-1:0]    up_size,
  input  logic [N*AW-1:0]   up_addr,
  input  logic [N*DW/8-1:0] up_strobe,
  input  logic [N*DW-1:0]   up_wdata,
  output logic [N-1:0]      up_data_ok,
  output logic [DW-1:0]     up_rdata,
  output logic              dn_valid,
  output logic              dn_write,
  output logic [2:0]        dn_size,
  output logic [AW-1:0]     dn_addr,
  output logic [DW/8-1:0]   dn_strobe,
  output logic [DW-1:0]     dn_wdata,
  input  logic              dn_ok,
  input  logic [DW-1:0]     dn_rdata,
  output logic              busy
);

  import mem_port_arbiter_pkg::*;

  localparam int IW = $clog2(N);
  localparam int SW = DW / 8;

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic [IW-1:0] gnt_idx;
  logic          any;

  logic          l_write;
  logic [2:0]    l_size;
  logic [AW-1:0] l_addr;
  logic [SW-1:0] l_strobe;
  logic [DW-1:0] l_wdata;

  logic [2:0]    size_a   [N];
  logic [AW-1:0] addr_a   [N];
  logic [SW-1:0] strobe_a [N];
  logic [DW-1:0] wdata_a  [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign size_a[i]   = up_size[i*3 +: 3];
    assign addr_a[i]   = up_addr[i*AW +: AW];
    assign strobe_a[i] = up_strobe[i*SW +: SW];
    assign wdata_a[i]  = up_wdata[i*DW +: DW];
  end

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req     (up_valid),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // grant/complete FSM with request latch and last-grant pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      ptr      <= IW'(N - 1);
      sel      <= '0;
      l_write  <= 1'b0;
      l_size   <= '0;
      l_addr   <= '0;
      l_strobe <= '0;
      l_wdata  <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (any) begin
            sel      <= gnt_idx;
            l_write  <= up_write[gnt_idx];
            l_size   <= size_a[gnt_idx];
            l_addr   <= addr_a[gnt_idx];
            l_strobe <= strobe_a[gnt_idx];
            l_wdata  <= wdata_a[gnt_idx];
            state    <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (dn_ok) begin
            ptr   <= sel;
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign busy      = (state == ARB_BUSY);
  assign dn_valid  = busy;
  assign dn_write  = l_write;
  assign dn_size   = l_size;
  assign dn_addr   = l_addr;
  assign dn_strobe = l_strobe;
  assign dn_wdata  = l_wdata;

  // completion forwarded to the owner in the dn_ok cycle
  always_comb begin
    up_data_ok = '0;
    up_rdata   = '0;
    if (busy && dn_ok) begin
      up_data_ok[sel] = 1'b1;
      up_rdata        = dn_rdata;
    end
  end

endmodule
